// File: rtl/gpio_display_arbiter.sv
// Round-robin owner selection for the shared GPIO matrix/hex display.
// The owner's frame is forwarded registered, and a blank gap is inserted on every ownership change.
module gpio_display_arbiter #(
    parameter int         N_REQ        = 4,
    parameter int         MAX_HOLD     = 50_000_000,
    parameter int         BLANK_CYCLES = 131_072,
    parameter logic [7:0] HEX_BLANK    = 8'h00
) (
    input  logic                 clock_50,
    input  logic                 reset,
    input  logic [N_REQ-1:0]     req,
    input  logic                 lock,
    input  logic [N_REQ*128-1:0] rows_in,
    input  logic [N_REQ*64-1:0]  hex_in,
    output logic [N_REQ-1:0]     gnt,
    output logic [2:0]           owner,
    output logic                 owner_vld,
    output logic [127:0]         rows_out,
    output logic [63:0]          hex_out
);
    // state   | meaning
    // S_IDLE  | no owner, outputs blank, arbitrate whenever any req is up
    // S_GRANT | owner's frame forwarded every cycle, dwell counting toward preemption
    // S_BLANK | gap between owners, outputs blank, req ignored

    localparam int              PTR_W     = $clog2(N_REQ);
    localparam int              DW_W      = $clog2(MAX_HOLD);
    localparam int              BC_W      = $clog2(BLANK_CYCLES) + 1;
    localparam logic [DW_W-1:0] DWELL_MAX = DW_W'(MAX_HOLD - 1);
    localparam logic [BC_W-1:0] BLANK_LD  = BC_W'(BLANK_CYCLES - 1);
    localparam logic [63:0]     HEX_OFF   = {8{HEX_BLANK}};

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_BLANK = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [N_REQ-1:0] gnt_q, gnt_d;
    logic [2:0]       owner_q, owner_d;
    logic             owner_vld_q, owner_vld_d;
    logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [DW_W-1:0]  dwell_q, dwell_d;
    logic [BC_W-1:0]  blank_cnt_q, blank_cnt_d;
    logic [127:0]     rows_out_q, rows_out_d;
    logic [63:0]      hex_out_q, hex_out_d;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic               pick_vld;
    logic [2:0]         pick_idx;
    logic [127:0]       owner_rows;
    logic [63:0]        owner_hex;
    logic               owner_req;
    logic               waiter;
    logic               release_w;
    logic [PTR_W-1:0]   next_ptr;

    // Rotating a doubled copy puts rr_ptr at bit 0, so the first set bit wins.
    assign req_dbl = {req, req};
    assign req_rot = req_dbl[rr_ptr_q +: N_REQ];

    always_comb begin
        pick_vld = 1'b0;
        pick_idx = 3'd0;
        for (int k = 0; k < N_REQ; k++) begin
            if (!pick_vld && req_rot[k]) begin
                pick_vld = 1'b1;
                pick_idx = 3'((int'(rr_ptr_q) + k) % N_REQ);
            end
        end
    end

    always_comb begin
        owner_rows = '0;
        owner_hex  = '0;
        owner_req  = 1'b0;
        for (int i = 0; i < N_REQ; i++) begin
            if (owner_q == 3'(i)) begin
                owner_rows = rows_in[i*128 +: 128];
                owner_hex  = hex_in[i*64 +: 64];
                owner_req  = req[i];
            end
        end
    end

    assign waiter    = (req & ~gnt_q) != '0;
    assign release_w = !owner_req || ((dwell_q == DWELL_MAX) && !lock && waiter);
    assign next_ptr  = (owner_q == 3'(N_REQ - 1)) ? '0 : PTR_W'(owner_q + 3'd1);

    always_ff @(posedge clock_50) begin
        if (reset) begin
            state_q     <= S_IDLE;
            gnt_q       <= '0;
            owner_q     <= '0;
            owner_vld_q <= 1'b0;
            rr_ptr_q    <= '0;
            dwell_q     <= '0;
            blank_cnt_q <= '0;
            rows_out_q  <= '0;
            hex_out_q   <= HEX_OFF;
        end else begin
            state_q     <= state_d;
            gnt_q       <= gnt_d;
            owner_q     <= owner_d;
            owner_vld_q <= owner_vld_d;
            rr_ptr_q    <= rr_ptr_d;
            dwell_q     <= dwell_d;
            blank_cnt_q <= blank_cnt_d;
            rows_out_q  <= rows_out_d;
            hex_out_q   <= hex_out_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (pick_vld) state_d = S_GRANT;
            S_GRANT: if (release_w) state_d = S_BLANK;
            S_BLANK: if (blank_cnt_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        gnt_d       = gnt_q;
        owner_d     = owner_q;
        owner_vld_d = owner_vld_q;
        rr_ptr_d    = rr_ptr_q;
        dwell_d     = dwell_q;
        blank_cnt_d = blank_cnt_q;
        rows_out_d  = '0;
        hex_out_d   = HEX_OFF;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    gnt_d       = N_REQ'(1) << pick_idx;
                    owner_d     = pick_idx;
                    owner_vld_d = 1'b1;
                    dwell_d     = '0;
                end
            end
            S_GRANT: begin
                if (dwell_q != DWELL_MAX) dwell_d = dwell_q + 1'b1;
                if (release_w) begin
                    gnt_d       = '0;
                    owner_vld_d = 1'b0;
                    rr_ptr_d    = next_ptr;
                    blank_cnt_d = BLANK_LD;
                end else begin
                    rows_out_d = owner_rows;
                    hex_out_d  = owner_hex;
                end
            end
            S_BLANK: begin
                if (blank_cnt_q != '0) blank_cnt_d = blank_cnt_q - 1'b1;
            end
            default: ;
        endcase
    end

    assign gnt       = gnt_q;
    assign owner     = owner_q;
    assign owner_vld = owner_vld_q;
    assign rows_out  = rows_out_q;
    assign hex_out   = hex_out_q;

    gnt_onehot_a: assert property (@(posedge clock_50) disable iff (reset) $onehot0(gnt_q));

endmodule
